// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_adder_slice.sv
// Combinational 4-bit ripple-carry slice; c3 is the carry into bit 3 for overflow detection.
module nibble_adder_slice
   import nibble_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] x,
   input  logic [NIBBLE_W-1:0] y,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co,
   output logic                c3
);

   logic [NIBBLE_W:0] carry_s;

   // Ripple the carry bit by bit across the nibble
   always_comb begin
      carry_s    = {(NIBBLE_W+1){1'b0}};
      s          = {NIBBLE_W{1'b0}};
      carry_s[0] = ci;
      for (int i = 0; i < NIBBLE_W; i++) begin
         s[i]         = x[i] ^ y[i] ^ carry_s[i];
         carry_s[i+1] = (x[i] & y[i]) | (x[i] & carry_s[i]) | (y[i] & carry_s[i]);
      end
   end

   assign co = carry_s[NIBBLE_W];
   assign c3 = carry_s[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit slice, one nibble per clock, with start/done handshake.
// Define NIBBLE_ADDER_SUB_EN to add a 'sub' input selecting a - b.
module nibble_serial_adder_ctrl
   import nibble_adder_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef NIBBLE_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NNIB  = WIDTH / NIBBLE_W;
   localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

   state_t               state_r;
   state_t               state_nxt_s;
   logic [IDX_W-1:0]     idx_r;
   logic [WIDTH-1:0]     a_sh_r;
   logic [WIDTH-1:0]     b_sh_r;
   logic                 carry_r;
   logic [WIDTH-1:0]     sum_r;
   logic                 cout_r;
   logic                 ovf_r;
   logic                 zero_r;
   logic                 busy_r;
   logic                 done_r;

   logic                 accept_s;
   logic                 last_pass_s;
   logic [WIDTH-1:0]     b_load_s;
   logic                 carry_load_s;
   logic [NIBBLE_W-1:0]  slice_sum_s;
   logic                 slice_co_s;
   logic                 slice_c3_s;
   logic [WIDTH-1:0]     sum_nxt_s;

   nibble_adder_slice u_slice (
      .x  (a_sh_r[NIBBLE_W-1:0]),
      .y  (b_sh_r[NIBBLE_W-1:0]),
      .ci (carry_r),
      .s  (slice_sum_s),
      .co (slice_co_s),
      .c3 (slice_c3_s)
   );

   // Next-state decode and acceptance of a new operation
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      last_pass_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = RUN;
               accept_s    = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (idx_r == LAST_IDX) begin
               state_nxt_s = DONE;
               last_pass_s = 1'b1;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Operand conditioning on load: subtraction is a + ~b + 1
   always_comb begin
`ifdef NIBBLE_ADDER_SUB_EN
      if (sub) begin
         b_load_s     = ~b;
         carry_load_s = 1'b1;
      end else begin
         b_load_s     = b;
         carry_load_s = cin;
      end
`else
      b_load_s     = b;
      carry_load_s = cin;
`endif
   end

   // Result with the current pass's nibble merged in; the final pass uses it for zero
   always_comb begin
      sum_nxt_s = sum_r;
      sum_nxt_s[idx_r*NIBBLE_W +: NIBBLE_W] = slice_sum_s;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath: operand shifters, carry FF, nibble index, result and flags
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_r   <= {IDX_W{1'b0}};
         a_sh_r  <= {WIDTH{1'b0}};
         b_sh_r  <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         sum_r   <= {WIDTH{1'b0}};
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
         zero_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s != IDLE);
         done_r <= (state_nxt_s == DONE);
         if (accept_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b_load_s;
            carry_r <= carry_load_s;
            idx_r   <= {IDX_W{1'b0}};
         end else if (state_r == RUN) begin
            a_sh_r  <= {{NIBBLE_W{1'b0}}, a_sh_r[WIDTH-1:NIBBLE_W]};
            b_sh_r  <= {{NIBBLE_W{1'b0}}, b_sh_r[WIDTH-1:NIBBLE_W]};
            carry_r <= slice_co_s;
            sum_r   <= sum_nxt_s;
            if (last_pass_s) begin
               idx_r  <= {IDX_W{1'b0}};
               cout_r <= slice_co_s;
               ovf_r  <= slice_co_s ^ slice_c3_s;
               zero_r <= (sum_nxt_s == {WIDTH{1'b0}});
            end else begin
               idx_r  <= idx_r + 1'b1;
            end
         end
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign sum  = sum_r;
   assign cout = cout_r;
   assign ovf  = ovf_r;
   assign zero = zero_r;

endmodule
